// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared 8N1 framing constants, receiver state encoding and
//               baud divisor helper for the on-chip UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  function automatic int calc_cycles(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for asynchronous inputs, reset to ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 serial receiver with start validation, framing/overrun
//               detection and a one-entry ready/valid holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CYCLES = calc_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE = CYCLES / 2;
  localparam int CNT_W  = $clog2(CYCLES);

  localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_sample = CNT_W'(SAMPLE);
  localparam logic [2:0]       c_idx_last   = 3'(DATA_BITS - 1);

  logic                 w_rx;
  logic                 w_byte_done;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [1:0]           r_primed;
  logic                 r_armed;
  logic                 r_framing_error;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_overrun;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (w_rx)
  );

  assign w_byte_done = (r_state == ST_STOP) && (r_cnt == c_cnt_last) && w_rx;

  // The synchroniser resets high, so its output is not a real line sample
  // until two clocks after reset; arming waits for that before trusting w_rx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shreg         <= '0;
      r_primed        <= '0;
      r_armed         <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_primed        <= {r_primed[0], 1'b1};
      r_framing_error <= 1'b0;
      if (r_primed[1] && w_rx) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_armed && !w_rx) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == c_cnt_sample) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt     <= '0;
            r_shreg   <= {w_rx, r_shreg[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == c_idx_last) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Leave at the stop-bit sample so a following start edge is seen.
          if (r_cnt == c_cnt_last) begin
            r_cnt           <= '0;
            r_state         <= ST_IDLE;
            r_framing_error <= !w_rx;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_byte_done) begin
        if (!r_valid || data_out_ready) begin
          r_data  <= r_shreg;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && data_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign framing_error  = r_framing_error;
  assign overrun        = r_overrun;
  assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
